// File: rtl/mips_axi_pkg.sv
// Shared definitions for the MIPS core's SRAM-to-AXI bridges.
// The data-side bridge uses this package, and an instruction-side twin can reuse it.
package mips_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } bridge_state_e;

  // Fixed AXI fields; the SoC top ties these off.
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Data-side bridge: turns one M-stage load/store into a single-beat AXI transaction
// and keeps the core stalled until the beat completes.
module data_sram_axi_bridge
  import mips_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID   = 4'd1,
  parameter bit         ALIGN_RD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_ren,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        d_stall,
  input  logic        all_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          aw_ok_q, aw_ok_d;
  logic          w_ok_q, w_ok_d;
  logic          req;

  assign req     = mem_en & (mem_ren | (mem_wen != 4'b0000));
  assign d_stall = req & (state_q != DONE);

  // AXI payload comes only from the latched copies, so it stays stable while valid is high.
  assign arid      = AXI_ID;
  assign awid      = AXI_ID;
  assign araddr    = ALIGN_RD ? word_align(addr_q) : addr_q;
  assign awaddr    = word_align(addr_q);
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign mem_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      aw_ok_q <= 1'b0;
      w_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q  <= w_ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    aw_ok_d = aw_ok_q;
    w_ok_d  = w_ok_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        aw_ok_d = 1'b0;
        w_ok_d  = 1'b0;
        if (req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wen;
          // A store wins if the core also raised mem_ren.
          state_d = (mem_wen != 4'b0000) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        awvalid = !aw_ok_q;
        wvalid  = !w_ok_q;
        if (awvalid && awready) aw_ok_d = 1'b1;
        if (wvalid && wready)   w_ok_d  = 1'b1;
        if (aw_ok_d && w_ok_d)  state_d = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = DONE;
      end
      DONE: begin
        // Wait for the whole pipeline to advance so the held request is not reissued.
        if (!all_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Self-checking bench for data_sram_axi_bridge: a delay-programmable AXI slave,
// a transaction-level reference model checked every cycle, and directed literal checks.
module tb_data_sram_axi_bridge;

  localparam bit ALIGN = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_ren, all_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wen;
  logic        d_stall;
  logic [3:0]  arid, awid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;

  data_sram_axi_bridge #(.AXI_ID(4'd1), .ALIGN_RD(ALIGN)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .d_stall(d_stall), .all_stall(all_stall),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Slave: each ready/valid answers after a programmable number of waiting cycles.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    case (a)
      32'h1FC0_0004: return 32'hDEAD_BEEF;
      32'h0000_0010: return 32'h1234_5678;
      32'h0000_0014: return 32'hCAFE_F00D;
      default:       return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign rvalid  = rready  && (r_cnt  >= r_dly);
  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign bvalid  = bready  && (b_cnt  >= b_dly);
  assign rdata   = rvalid ? slave_word(araddr) : 32'h0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      r_cnt  <= (rready  && !rvalid)  ? r_cnt  + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
      b_cnt  <= (bready  && !bvalid)  ? b_cnt  + 1 : 0;
    end
  end

  // Reference model: one outstanding transaction tracked by which handshakes have happened.
  logic        m_active, m_write, m_ar, m_r, m_aw, m_w, m_b;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic        req_in, e_arvalid, e_rready, e_awvalid, e_wvalid, e_bready, e_done, e_dstall;

  assign req_in = mem_en && (mem_ren || (mem_wen != 4'b0000));

  always_comb begin
    e_arvalid = m_active && !m_write && !m_ar;
    e_rready  = m_active && !m_write && m_ar && !m_r;
    e_awvalid = m_active && m_write && !m_aw;
    e_wvalid  = m_active && m_write && !m_w;
    e_bready  = m_active && m_write && m_aw && m_w && !m_b;
    e_done    = m_active && (m_write ? m_b : m_r);
    e_dstall  = req_in && !e_done;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0; m_write <= 1'b0;
      m_ar <= 1'b0; m_r <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b0;
      m_addr <= 32'h0; m_wdata <= 32'h0; m_rdata <= 32'h0; m_strb <= 4'h0;
    end else if (!m_active) begin
      if (req_in) begin
        m_active <= 1'b1;
        m_write  <= (mem_wen != 4'b0000);
        m_addr   <= mem_addr;
        m_wdata  <= mem_wdata;
        m_strb   <= mem_wen;
        m_ar <= 1'b0; m_r <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b0;
      end
    end else begin
      if (e_arvalid && arready) m_ar <= 1'b1;
      if (e_rready && rvalid) begin
        m_r     <= 1'b1;
        m_rdata <= rdata;
      end
      if (e_awvalid && awready) m_aw <= 1'b1;
      if (e_wvalid && wready)   m_w  <= 1'b1;
      if (e_bready && bvalid)   m_b  <= 1'b1;
      if (e_done && !all_stall) m_active <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("arvalid",   32'(arvalid),   32'(e_arvalid));
    checkOutput("rready",    32'(rready),    32'(e_rready));
    checkOutput("awvalid",   32'(awvalid),   32'(e_awvalid));
    checkOutput("wvalid",    32'(wvalid),    32'(e_wvalid));
    checkOutput("bready",    32'(bready),    32'(e_bready));
    checkOutput("d_stall",   32'(d_stall),   32'(e_dstall));
    checkOutput("araddr",    araddr,    ALIGN ? {m_addr[31:2], 2'b00} : m_addr);
    checkOutput("awaddr",    awaddr,    {m_addr[31:2], 2'b00});
    checkOutput("wdata",     wdata,     m_wdata);
    checkOutput("wstrb",     32'(wstrb),     32'(m_strb));
    checkOutput("mem_rdata", mem_rdata, m_rdata);
    checkOutput("arid",      32'(arid),      32'd1);
    checkOutput("awid",      32'(awid),      32'd1);
  end

  // Cycle counters and last-seen payloads for the directed checks.
  int n_ds = 0, n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;

  always @(negedge clk) begin
    if (d_stall) n_ds <= n_ds + 1;
    if (arvalid) begin n_ar <= n_ar + 1; seen_araddr <= araddr; end
    if (awvalid) begin n_aw <= n_aw + 1; seen_awaddr <= awaddr; end
    if (wvalid)  begin n_w <= n_w + 1; seen_wdata <= wdata; seen_wstrb <= wstrb; end
    if (bready)  n_b <= n_b + 1;
  end

  int d_ds, d_ar, d_aw, d_w, d_b;

  // Issue one access, scramble core inputs mid-flight, wait for DONE, optionally hold all_stall.
  task automatic applyStimulus(input logic ren, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wd, input int hold);
    int b_ds, b_ar, b_aw, b_w, b_b;
    bit done;
    @(posedge clk); #1;
    b_ds = n_ds; b_ar = n_ar; b_aw = n_aw; b_w = n_w; b_b = n_b;
    mem_en = 1'b1; mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_wdata = wd;
    all_stall = (hold > 0);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!d_stall) done = 1'b1;
      else if (i == 1) begin
        #1 mem_addr = ~addr; mem_wdata = ~wd;
      end
    end
    #1;
    if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
    if (hold > 0) begin
      repeat (hold - 1) begin @(posedge clk); @(negedge clk); end
      @(posedge clk); #1 all_stall = 1'b0;
      @(negedge clk); #1;
    end
    d_ds = n_ds - b_ds; d_ar = n_ar - b_ar; d_aw = n_aw - b_aw; d_w = n_w - b_w; d_b = n_b - b_b;
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1 mem_en = 1'b0; mem_ren = 1'b0; mem_wen = 4'h0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst = 1'b0; mem_en = 1'b0; mem_ren = 1'b0; mem_wen = 4'h0;
    mem_addr = 32'h0; mem_wdata = 32'h0; all_stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("rst_awvalid", 32'(awvalid), 32'd0);
    checkOutput("rst_mem_rdata", mem_rdata, 32'h0);
    checkOutput("rst_wstrb", 32'(wstrb), 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    applyStimulus(1'b1, 4'h0, 32'h1FC0_0007, 32'h0, 0);
    checkOutput("rd_araddr_aligned", seen_araddr, 32'h1FC0_0004);
    checkOutput("rd_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_dstall_cycles", 32'(d_ds), 32'd3);
    checkOutput("rd_arvalid_cycles", 32'(d_ar), 32'd1);
    go_idle(1);

    aw_dly = 2;
    applyStimulus(1'b0, 4'b0011, 32'h0000_0102, 32'h0000_ABCD, 0);
    checkOutput("wr_wvalid_cycles", 32'(d_w), 32'd1);
    checkOutput("wr_awvalid_cycles", 32'(d_aw), 32'd3);
    checkOutput("wr_bready_cycles", 32'(d_b), 32'd1);
    checkOutput("wr_dstall_cycles", 32'(d_ds), 32'd5);
    checkOutput("wr_wstrb", 32'(seen_wstrb), 32'b0011);
    checkOutput("wr_awaddr", seen_awaddr, 32'h0000_0100);
    checkOutput("wr_wdata", seen_wdata, 32'h0000_ABCD);
    checkOutput("wr_rdata_kept", mem_rdata, 32'hDEAD_BEEF);
    aw_dly = 0;
    go_idle(1);

    applyStimulus(1'b1, 4'h0, 32'h0000_0020, 32'h0, 4);
    checkOutput("hold_arvalid_cycles", 32'(d_ar), 32'd1);
    checkOutput("hold_dstall_cycles", 32'(d_ds), 32'd3);
    checkOutput("hold_mem_rdata", mem_rdata, 32'h5A5A_5A7A);
    go_idle(1);

    applyStimulus(1'b1, 4'b1111, 32'h0000_0040, 32'h1122_3344, 0);
    checkOutput("wwin_arvalid_cycles", 32'(d_ar), 32'd0);
    checkOutput("wwin_awvalid_cycles", 32'(d_aw), 32'd1);
    checkOutput("wwin_wstrb", 32'(seen_wstrb), 32'b1111);
    go_idle(1);

    applyStimulus(1'b1, 4'h0, 32'h0000_0010, 32'h0, 0);
    checkOutput("b2b_first_rdata", mem_rdata, 32'h1234_5678);
    applyStimulus(1'b1, 4'h0, 32'h0000_0014, 32'h0, 0);
    checkOutput("b2b_second_rdata", mem_rdata, 32'hCAFE_F00D);
    checkOutput("b2b_second_araddr", seen_araddr, 32'h0000_0014);
    go_idle(1);

    r_dly = 6;
    @(posedge clk); #1;
    mem_en = 1'b1; mem_ren = 1'b1; mem_wen = 4'h0; mem_addr = 32'h0000_0044;
    begin
      bit seen_rr = 1'b0;
      for (int i = 0; i < 20 && !seen_rr; i++) begin
        @(negedge clk);
        if (rready) seen_rr = 1'b1;
      end
      if (!seen_rr) checkOutput("rst_rd_data_timeout", 32'd0, 32'd1);
    end
    #2 rst = 1'b0; mem_en = 1'b0;
    #1;
    checkOutput("midrst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("midrst_rready", 32'(rready), 32'd0);
    checkOutput("midrst_dstall", 32'(d_stall), 32'd0);
    checkOutput("midrst_mem_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b1; r_dly = 0;
    @(negedge clk); #1;
    checkOutput("postrst_rready", 32'(rready), 32'd0);
    checkOutput("postrst_arvalid", 32'(arvalid), 32'd0);

    applyStimulus(1'b1, 4'h0, 32'h0000_0010, 32'h0, 0);
    checkOutput("recover_rdata", mem_rdata, 32'h1234_5678);
    checkOutput("recover_dstall_cycles", 32'(d_ds), 32'd3);
    go_idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
